// File: rtl/imem_program_loader.sv
// imem_program_loader: command-driven byte-serial instruction memory loader with core start control
module imem_program_loader #(
  parameter int ADDR_W = 8,
  parameter int CMD_W  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [CMD_W-1:0]  cmd_type,
  input  logic [31:0]       cmd_data,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              start,
  output logic              busy,
  output logic              err
);
  localparam logic [CMD_W-1:0] SET_ADDR   = CMD_W'(0);
  localparam logic [CMD_W-1:0] WRITE_WORD = CMD_W'(1);
  localparam logic [CMD_W-1:0] LAUNCH     = CMD_W'(2);
  typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;
  state_t            state, state_n;
  logic [ADDR_W-1:0] ptr, ptr_n, addr_n;
  logic [1:0]        beat, beat_n;
  logic [31:0]       word, word_n;
  logic [7:0]        wdata_n;
  logic              err_n;
  assign cmd_ready = state == IDLE;
  // state and datapath registers
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      ptr   <= '0;
      beat  <= '0;
      word  <= '0;
    end else begin
      state <= state_n;
      ptr   <= ptr_n;
      beat  <= beat_n;
      word  <= word_n;
    end
  // next state: decode accepted commands in IDLE, step through four beats in WRITE
  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    beat_n  = beat;
    word_n  = word;
    err_n   = err;
    if (state == IDLE && cmd_valid) begin
      if (cmd_type == SET_ADDR) begin
        ptr_n = {cmd_data[ADDR_W-1:2], 2'b00};
        err_n = err | (|cmd_data[1:0]);
      end else if (cmd_type == WRITE_WORD) begin
        word_n  = cmd_data;
        beat_n  = '0;
        state_n = WRITE;
      end else if (cmd_type == LAUNCH) begin
        state_n = DONE;
      end else begin
        err_n = 1'b1;
      end
    end else if (state == WRITE) begin
      beat_n = beat + 2'd1;
      if (beat == 2'd3) begin
        state_n = IDLE;
        ptr_n   = ptr + ADDR_W'(4);
        err_n   = err | (ptr_n == '0);
      end
    end
  end
  // output values for the next cycle, MSB first so it lands at the lowest address
  always_comb begin
    addr_n  = ptr_n + ADDR_W'(beat_n);
    wdata_n = word_n[{~beat_n, 3'b000} +: 8];
  end
  // registered outputs
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      start     <= 1'b0;
      busy      <= 1'b0;
      err       <= 1'b0;
    end else begin
      mem_we    <= state_n == WRITE;
      mem_addr  <= addr_n;
      mem_wdata <= wdata_n;
      start     <= state_n == DONE;
      busy      <= state_n == WRITE;
      err       <= err_n;
    end
endmodule

// File: doc/imem_program_loader.md
Name: imem_program_loader

Overview:
Hardware replacement for direct instruction-memory preloading. Accepts a command stream over a valid/ready handshake and writes 32-bit instruction words into the byte-wide instruction memory. Each word is written most-significant byte first, so the MSB lands at the lowest address, matching the instruction-memory byte order. After loading finishes, the block raises and holds the core's start signal. It sits between an external host/debug port and the riscv_instmem write port and drives the start input of riscv32.

Parameters:
ADDR_W, 8, byte-address width of the instruction memory (256 bytes).
CMD_W, 2, width of the command-type field.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
cmd_valid  in  1  command present.
cmd_ready  out  1  block can accept a command; combinational, equals (state==IDLE).
cmd_type  in  CMD_W  00 SET_ADDR, 01 WRITE_WORD, 10 LAUNCH, 11 reserved.
cmd_data  in  32  address (SET_ADDR) or instruction word (WRITE_WORD); ignored otherwise.
mem_we  out  1  byte write enable to instruction memory.
mem_addr  out  ADDR_W  byte address.
mem_wdata  out  8  byte data.
start  out  1  core start; held high after LAUNCH.
busy  out  1  high while in WRITE.
err  out  1  sticky error flag.

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous and active-low. While rst_n is low: state=IDLE, ptr=0, beat=0, mem_we=0, mem_addr=0, mem_wdata=0, start=0, busy=0, err=0.
- Registered outputs: all outputs except cmd_ready are registered.
- Handshake: a command is accepted on a rising edge where cmd_valid && cmd_ready. cmd_valid may be held across the non-ready cycles; the command is taken exactly once.
- FSM states: IDLE, WRITE, DONE.
- IDLE, SET_ADDR accepted:
  - ptr <= {cmd_data[ADDR_W-1:2],2'b00}.
  - If cmd_data[1:0]!=0, set err. The aligned-down pointer is still used.
  - Upper cmd_data bits are ignored.
  - Remain in IDLE.
- IDLE, WRITE_WORD accepted: latch the word, beat<=0, go to WRITE.
- IDLE, LAUNCH accepted: go to DONE. start=1 from the next edge.
- IDLE, reserved type accepted: consumed with no other effect; set err.
- WRITE: exactly 4 consecutive cycles with mem_we=1, beat 0..3.
  - mem_addr = ptr+beat.
  - mem_wdata = word[31-8*beat -: 8].
  - The first byte is visible in the cycle after the accepting edge.
  - On the edge leaving beat 3: ptr <= ptr+4 (modulo 2^ADDR_W), return to IDLE, mem_we <= 0.
  - Peak throughput: one word per 5 cycles.
- Pointer wrap: if ptr+4 wraps to 0 (ptr was 2^ADDR_W-4), set err and continue from 0.
- DONE:
  - start=1, cmd_ready=0, mem_we=0.
  - All commands are stalled.
  - Exit only via reset.
- busy = (state==WRITE).
- err is sticky until reset.
- Reset mid-write: outputs clear asynchronously, including mem_we dropping with no further bytes. Bytes already written stay in memory. start falls immediately.
- No simultaneous-event ambiguity: commands are only taken in IDLE, and the memory port is only driven in WRITE.

Test Plan:
- Reset; SET_ADDR 0x00; WRITE_WORD 0x00100133 -> mem_we high 4 consecutive cycles, addr 0,1,2,3, data 00,10,01,33. busy high for those 4 cycles. err=0.
- cmd_valid held with WRITE_WORD 0x402081B3 then 0x0020F233 -> cmd_ready low 4 cycles between accepts. Addresses 4..7 then 8..11, data 40,20,81,B3 then 00,20,F2,33. Exactly one IDLE cycle between bursts.
- SET_ADDR 0x4C; WRITE_WORD 0x00022303; WRITE_WORD 0x82A48463 -> addrs 76..83 with bytes 00,02,23,03,82,A4,84,63. Then SET_ADDR 0x4E -> err=1, and the next write lands at 0x4C.
- SET_ADDR 0xFC; WRITE_WORD 0xDEADBEEF; WRITE_WORD 0x00000013 -> bytes DE,AD,BE,EF at 252..255; err=1; second word at 0..3.
- LAUNCH -> start=1 on the next edge and cmd_ready=0. A subsequent WRITE_WORD with cmd_valid held for 10 cycles -> no mem_we. Assert rst_n low -> start=0 and cmd_ready=1 without waiting for a clock edge.
- Reset mid-WRITE, rst_n asserted during beat 1 -> mem_we falls asynchronously with no beat 2/3 writes. After release: ptr=0, err=0, cmd_ready=1.
